sdram_multiport_arbiter: RTL and testbench

Parametrised N-port front end that shares one `sdram_controller` command interface among several clients. Selects one pending client request at a time by round-robin or fixed priority, issues it downstream as a single-cycle command, and routes burst read data, per-beat write completions and timeout errors back to the owning port. It sits between user logic and the chip-specific controller wrapper, replacing the single-client `command` / `data_*` connection.

---
 rtl/sdram_multiport_arbiter.sv | 158 +++++++++++++++
 tb/tb_sdram_multiport_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_multiport_arbiter.sv
// N-port front end sharing one sdram_controller command interface.
// One client transaction at a time: arbitrate in IDLE, issue for one cycle, then collect beats in WAIT.
module sdram_multiport_arbiter #(
    parameter int PORTS              = 4,
    parameter int ADDRESS_WIDTH      = 22,
    parameter int DATA_WIDTH         = 16,
    parameter int READ_BURST_LENGTH  = 1,
    parameter int WRITE_BURST_LENGTH = 1,
    parameter int PRIORITY_MODE      = 0,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2*PORTS-1:0]               client_command,
    input  logic [ADDRESS_WIDTH*PORTS-1:0]   client_address,
    input  logic [DATA_WIDTH*PORTS-1:0]      client_data_write,
    output logic [PORTS-1:0]                 client_grant,
    output logic [DATA_WIDTH-1:0]            client_data_read,
    output logic [PORTS-1:0]                 client_data_read_valid,
    output logic [PORTS-1:0]                 client_data_write_done,
    output logic [PORTS-1:0]                 client_error,
    output logic                             busy,
    output logic [1:0]                       command,
    output logic [ADDRESS_WIDTH-1:0]         data_address,
    output logic [DATA_WIDTH-1:0]            data_write,
    input  logic [DATA_WIDTH-1:0]            data_read,
    input  logic                             data_read_valid,
    input  logic                             data_write_done
);

    localparam int OW        = $clog2(PORTS);
    localparam int MAX_BURST = (READ_BURST_LENGTH > WRITE_BURST_LENGTH) ? READ_BURST_LENGTH : WRITE_BURST_LENGTH;
    localparam int BW        = $clog2(MAX_BURST + 1);
    localparam int TW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] CMD_WRITE = 2'd1;
    localparam logic [1:0] CMD_READ  = 2'd2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                   state, state_next;
    logic [OW-1:0]            owner, last_granted, winner, sel;
    logic [1:0]               cmd_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [BW-1:0]            beat_count, burst_len;
    logic [TW-1:0]            timeout_count;
    logic [PORTS-1:0]         request;
    logic                     grant_valid, is_read, is_write, beat, last_beat, timeout_hit;

    always_comb begin
        for (int i = 0; i < PORTS; i++) begin
            request[i] = (client_command[2*i +: 2] == CMD_WRITE) || (client_command[2*i +: 2] == CMD_READ);
        end
    end

    // Scan candidates from farthest to nearest so the nearest pending port is the last one written.
    always_comb begin
        grant_valid = 1'b0;
        winner      = '0;
        sel         = '0;
        for (int k = PORTS; k >= 1; k--) begin
            if (PRIORITY_MODE == 1) sel = OW'(k - 1);
            else                    sel = OW'((int'(last_granted) + k) % PORTS);
            if (request[sel]) begin
                grant_valid = 1'b1;
                winner      = sel;
            end
        end
    end

    assign is_read     = (cmd_q == CMD_READ);
    assign is_write    = (cmd_q == CMD_WRITE);
    assign burst_len   = is_read ? BW'(READ_BURST_LENGTH) : BW'(WRITE_BURST_LENGTH);
    assign beat        = (state == WAIT) && ((is_read && data_read_valid) || (is_write && data_write_done));
    assign last_beat   = beat && ((beat_count + BW'(1)) == burst_len);
    // A beat landing on the terminal count takes precedence over the abort.
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (state == WAIT) && !beat && (timeout_count == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (last_beat || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner         <= '0;
            cmd_q         <= '0;
            addr_q        <= '0;
            last_granted  <= OW'(PORTS - 1);
            beat_count    <= '0;
            timeout_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner  <= winner;
                        cmd_q  <= client_command[winner*2 +: 2];
                        addr_q <= client_address[winner*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                    end
                end
                ISSUE: begin
                    beat_count    <= '0;
                    timeout_count <= '0;
                end
                WAIT: begin
                    if (beat) begin
                        beat_count    <= beat_count + BW'(1);
                        timeout_count <= '0;
                        if (last_beat) last_granted <= owner;
                    end else begin
                        if (TIMEOUT_CYCLES > 0) timeout_count <= timeout_count + TW'(1);
                        if (timeout_hit) last_granted <= owner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign client_data_read = data_read;

    always_comb begin
        client_grant           = '0;
        client_data_read_valid = '0;
        client_data_write_done = '0;
        client_error           = '0;
        command                = 2'b00;
        data_address           = '0;
        data_write             = '0;
        busy                   = (state != IDLE);
        case (state)
            ISSUE: begin
                command             = cmd_q;
                data_address        = addr_q;
                client_grant[owner] = 1'b1;
                data_write          = client_data_write[owner*DATA_WIDTH +: DATA_WIDTH];
            end
            WAIT: begin
                data_write                    = client_data_write[owner*DATA_WIDTH +: DATA_WIDTH];
                client_data_read_valid[owner] = is_read && data_read_valid;
                client_data_write_done[owner] = is_write && data_write_done;
                client_error[owner]           = timeout_hit;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sdram_multiport_arbiter.sv
// Directed bench for sdram_multiport_arbiter: a round-robin instance (read burst 1, write burst 4)
// and a fixed-priority instance (read burst 8), both with an 8-cycle timeout.
module tb_sdram_multiport_arbiter;

    localparam int P  = 4;
    localparam int AW = 22;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [2*P-1:0]  a_cmd, b_cmd;
    logic [AW*P-1:0] a_addr, b_addr;
    logic [DW*P-1:0] a_dw, b_dw;
    logic [P-1:0]    a_grant, a_rvalid, a_wdone, a_err;
    logic [P-1:0]    b_grant, b_rvalid, b_wdone, b_err;
    logic [DW-1:0]   a_cdr, b_cdr, a_dwr, b_dwr, a_rd, b_rd;
    logic [1:0]      a_command, b_command;
    logic [AW-1:0]   a_daddr, b_daddr;
    logic            a_busy, b_busy, a_rv, b_rv, a_wd, b_wd;

    sdram_multiport_arbiter #(
        .PORTS(P), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_BURST_LENGTH(1),
        .WRITE_BURST_LENGTH(4), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)
    ) dut_rr (
        .clk(clk), .reset(reset), .client_command(a_cmd), .client_address(a_addr),
        .client_data_write(a_dw), .client_grant(a_grant), .client_data_read(a_cdr),
        .client_data_read_valid(a_rvalid), .client_data_write_done(a_wdone),
        .client_error(a_err), .busy(a_busy), .command(a_command), .data_address(a_daddr),
        .data_write(a_dwr), .data_read(a_rd), .data_read_valid(a_rv), .data_write_done(a_wd)
    );

    sdram_multiport_arbiter #(
        .PORTS(P), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_BURST_LENGTH(8),
        .WRITE_BURST_LENGTH(1), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)
    ) dut_fp (
        .clk(clk), .reset(reset), .client_command(b_cmd), .client_address(b_addr),
        .client_data_write(b_dw), .client_grant(b_grant), .client_data_read(b_cdr),
        .client_data_read_valid(b_rvalid), .client_data_write_done(b_wdone),
        .client_error(b_err), .busy(b_busy), .command(b_command), .data_address(b_daddr),
        .data_write(b_dwr), .data_read(b_rd), .data_read_valid(b_rv), .data_write_done(b_wd)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        a_cmd = 8'b1010_1010;
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_command !== 2'b00) begin errors++; $display("[TB] FAIL reset_command: got %h expected 0", a_command); end
        checks++; if (a_grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant: got %b expected 0000", a_grant); end
        checks++; if (a_dwr !== 16'h0000) begin errors++; $display("[TB] FAIL reset_data_write: got %h expected 0000", a_dwr); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy_fp: got %b expected 0", b_busy); end
        a_cmd = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_read;
        a_addr = '0;
        a_addr[2*AW +: AW] = 22'h12345;
        a_cmd = 8'b0010_0000;
        tick();
        #1;
        checks++; if (a_grant !== 4'b0100) begin errors++; $display("[TB] FAIL read_grant: got %b expected 0100", a_grant); end
        checks++; if (a_command !== 2'd2) begin errors++; $display("[TB] FAIL read_command: got %h expected 2", a_command); end
        checks++; if (a_daddr !== 22'h12345) begin errors++; $display("[TB] FAIL read_address: got %h expected 12345", a_daddr); end
        a_cmd = '0;
        tick();
        a_rd = 16'hBEEF;
        a_rv = 1'b1;
        #1;
        checks++; if (a_rvalid !== 4'b0100) begin errors++; $display("[TB] FAIL read_valid: got %b expected 0100", a_rvalid); end
        checks++; if (a_cdr !== 16'hBEEF) begin errors++; $display("[TB] FAIL read_data: got %h expected BEEF", a_cdr); end
        checks++; if (a_command !== 2'd0) begin errors++; $display("[TB] FAIL read_command_wait: got %h expected 0", a_command); end
        tick();
        a_rv = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL read_idle: got %b expected 0", a_busy); end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp;
        do_reset();
        a_cmd = 8'b1010_1010;
        a_rv  = 1'b1;
        for (int t = 0; t < 6; t++) begin
            int n;
            n = 0;
            do begin
                tick();
                #1;
                n++;
            end while (a_grant == 4'b0000 && n < 8);
            exp = 4'(1 << (t % 4));
            checks++; if (a_grant !== exp) begin errors++; $display("[TB] FAIL rr_grant_%0d: got %b expected %b", t, a_grant, exp); end
        end
        a_cmd = '0;
        tick();
        tick();
        a_rv = 1'b0;
        tick();
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL rr_idle: got %b expected 0", a_busy); end
    endtask

    task automatic test_write_burst;
        logic [15:0] exp;
        a_dw = '0;
        a_dw[0 +: DW] = 16'h00A0;
        a_cmd = 8'b0000_0001;
        tick();
        a_wd = 1'b1;
        #1;
        checks++; if (a_grant !== 4'b0001) begin errors++; $display("[TB] FAIL wr_grant: got %b expected 0001", a_grant); end
        checks++; if (a_command !== 2'd1) begin errors++; $display("[TB] FAIL wr_command: got %h expected 1", a_command); end
        checks++; if (a_wdone !== 4'b0000) begin errors++; $display("[TB] FAIL wr_stray_done: got %b expected 0000", a_wdone); end
        a_cmd = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            exp = 16'(16'h00A0 + k);
            a_dw[0 +: DW] = exp;
            a_wd = 1'b1;
            #1;
            checks++; if (a_dwr !== exp) begin errors++; $display("[TB] FAIL wr_data_%0d: got %h expected %h", k, a_dwr, exp); end
            checks++; if (a_wdone !== 4'b0001) begin errors++; $display("[TB] FAIL wr_done_%0d: got %b expected 0001", k, a_wdone); end
        end
        tick();
        a_wd = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle: got %b expected 0", a_busy); end
        checks++; if (a_wdone !== 4'b0000) begin errors++; $display("[TB] FAIL wr_done_idle: got %b expected 0000", a_wdone); end
    endtask

    task automatic test_timeout;
        a_cmd = 8'b0000_1000;
        tick();
        a_cmd = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            #1;
            if (c == 7) begin
                checks++; if (a_err !== 4'b0000) begin errors++; $display("[TB] FAIL to_early: got %b expected 0000", a_err); end
            end
            if (c == 8) begin
                checks++; if (a_err !== 4'b0010) begin errors++; $display("[TB] FAIL to_error: got %b expected 0010", a_err); end
                checks++; if (a_busy !== 1'b1) begin errors++; $display("[TB] FAIL to_busy: got %b expected 1", a_busy); end
            end
        end
        tick();
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL to_idle: got %b expected 0", a_busy); end
        checks++; if (a_err !== 4'b0000) begin errors++; $display("[TB] FAIL to_err_clear: got %b expected 0000", a_err); end
        a_cmd = 8'b0000_1000;
        tick();
        a_cmd = '0;
        for (int c = 1; c <= 7; c++) tick();
        tick();
        a_rd = 16'h5A5A;
        a_rv = 1'b1;
        #1;
        checks++; if (a_err !== 4'b0000) begin errors++; $display("[TB] FAIL to_beat_wins: got %b expected 0000", a_err); end
        checks++; if (a_rvalid !== 4'b0010) begin errors++; $display("[TB] FAIL to_beat_valid: got %b expected 0010", a_rvalid); end
        tick();
        a_rv = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("[TB] FAIL to_beat_idle: got %b expected 0", a_busy); end
    endtask

    task automatic test_fixed_priority;
        int n;
        b_cmd = 8'b1000_1000;
        for (int t = 0; t < 3; t++) begin
            n = 0;
            do begin
                tick();
                #1;
                n++;
            end while (b_grant == 4'b0000 && n < 16);
            checks++; if (b_grant !== 4'b0010) begin errors++; $display("[TB] FAIL fp_grant_%0d: got %b expected 0010", t, b_grant); end
        end
        b_cmd = 8'b1000_0000;
        n = 0;
        do begin
            tick();
            #1;
            n++;
        end while (b_grant == 4'b0000 && n < 16);
        checks++; if (b_grant !== 4'b1000) begin errors++; $display("[TB] FAIL fp_grant_low: got %b expected 1000", b_grant); end
        b_cmd = '0;
        repeat (12) tick();
        #1;
        checks++; if (b_busy !== 1'b0) begin errors++; $display("[TB] FAIL fp_idle: got %b expected 0", b_busy); end
    endtask

    task automatic test_reset_mid_wait;
        b_cmd = 8'b0010_0000;
        tick();
        b_cmd = '0;
        #1;
        checks++; if (b_grant !== 4'b0100) begin errors++; $display("[TB] FAIL mid_grant: got %b expected 0100", b_grant); end
        tick();
        b_rd = 16'h1111;
        b_rv = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (b_rvalid !== 4'b0100) begin errors++; $display("[TB] FAIL mid_valid: got %b expected 0100", b_rvalid); end
        reset = 1'b1;
        #1;
        checks++; if (b_busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy: got %b expected 0", b_busy); end
        checks++; if (b_rvalid !== 4'b0000) begin errors++; $display("[TB] FAIL mid_valid_drop: got %b expected 0000", b_rvalid); end
        checks++; if (b_err !== 4'b0000) begin errors++; $display("[TB] FAIL mid_error: got %b expected 0000", b_err); end
        checks++; if (b_grant !== 4'b0000) begin errors++; $display("[TB] FAIL mid_grant_drop: got %b expected 0000", b_grant); end
        tick();
        reset = 1'b0;
        b_rv  = 1'b0;
        b_cmd = 8'b0000_0010;
        tick();
        #1;
        checks++; if (b_grant !== 4'b0001) begin errors++; $display("[TB] FAIL post_grant: got %b expected 0001", b_grant); end
        checks++; if (b_command !== 2'd2) begin errors++; $display("[TB] FAIL post_command: got %h expected 2", b_command); end
        b_cmd = '0;
        repeat (10) tick();
        #1;
        checks++; if (b_busy !== 1'b0) begin errors++; $display("[TB] FAIL post_idle: got %b expected 0", b_busy); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        a_cmd = '0; a_addr = '0; a_dw = '0; a_rd = '0; a_rv = 1'b0; a_wd = 1'b0;
        b_cmd = '0; b_addr = '0; b_dw = '0; b_rd = '0; b_rv = 1'b0; b_wd = 1'b0;
        tick();
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_burst();
        test_timeout();
        test_fixed_priority();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
